dmem_responder: RTL and testbench

//   Multi-cycle data-memory responder on the core's data port (target side of

---
 rtl/dmem_responder.sv | 137 +++++++++++++
 tb/tb_dmem_responder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: captures one request, waits WAIT_STATES
// cycles, then reads or writes a word-addressed RAM and pulses MemReadyM.
module dmem_responder #(
   parameter int unsigned DEPTH       = 64,
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemReqM,
   input  logic        MemWriteM,
   input  logic [31:0] DataAdrM,
   input  logic [31:0] WriteDataM,
   input  logic [3:0]  ByteEnM,
   output logic [31:0] ReadDataM,
   output logic        MemReadyM,
   output logic        MemErrM,
   output logic        MemStallM
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = 4;
   localparam int unsigned DW = 32;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [AW-1:0]  idx_q, idx_d;
   logic [DW-1:0]  wdata_q, wdata_d;
   logic           we_q, we_d;
   logic [3:0]     be_q, be_d;
   logic           err_q, err_d;
   logic [DW-1:0]  rdata_q, rdata_d;
   logic           ready_q, ready_d;
   logic           merr_q, merr_d;

   logic [DW-1:0]  mem [DEPTH];
   logic           req_err_c;
   logic [AW-1:0]  req_idx_c;
   logic           commit_c;

   // Misaligned or beyond the RAM (full-width compare, so high garbage errors)
   assign req_err_c = (DataAdrM[1:0] != 2'b00) || (DataAdrM >= DW'(4 * DEPTH));
   assign req_idx_c = DataAdrM[AW+1:2];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      be_d    = be_q;
      err_d   = err_q;
      rdata_d = '0;
      ready_d = 1'b0;
      merr_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (MemReqM) begin
               idx_d   = req_idx_c;
               wdata_d = WriteDataM;
               we_d    = MemWriteM;
               be_d    = ByteEnM;
               err_d   = req_err_c;
               if (WAIT_STATES == 0) begin
                  state_d = S_RESP;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = CW'(WAIT_STATES);
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = S_RESP;
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Response outputs are registered on the edge entering RESP; RAM cannot
      // change before then because writes only commit when leaving RESP.
      if (state_d == S_RESP) begin
         ready_d = 1'b1;
         merr_d  = err_d;
         if (!we_d && !err_d) rdata_d = mem[idx_d];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         be_q    <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         ready_q <= 1'b0;
         merr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         be_q    <= be_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         ready_q <= ready_d;
         merr_q  <= merr_d;
      end
   end

   // A reset during the access forces IDLE asynchronously, dropping the write
   assign commit_c = (state_q == S_RESP) && we_q && !err_q;

   always_ff @(posedge clk) begin
      if (commit_c) begin
         for (int b = 0; b < 4; b++) begin
            if (be_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
         end
      end
   end

   assign ReadDataM = rdata_q;
   assign MemReadyM = ready_q;
   assign MemErrM   = merr_q;
   assign MemStallM = MemReqM & ~ready_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: instance 0 has no wait states,
// instance 1 has two; both are checked against an array model of the RAM.
module tb_dmem_responder;

   localparam int unsigned DEPTH = 64;

   typedef struct packed {
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n [2];
   logic        req   [2];
   logic        we    [2];
   logic [31:0] adr   [2];
   logic [31:0] wd    [2];
   logic [3:0]  be    [2];
   logic [31:0] rd    [2];
   logic        rdy   [2];
   logic        merr  [2];
   logic        stall [2];

   int          errors = 0;
   int          checks = 0;
   exp_t        q0 [$];
   exp_t        q1 [$];
   logic [31:0] model [2][DEPTH];

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
      .clk(clk), .reset(rst_n[0]), .MemReqM(req[0]), .MemWriteM(we[0]),
      .DataAdrM(adr[0]), .WriteDataM(wd[0]), .ByteEnM(be[0]),
      .ReadDataM(rd[0]), .MemReadyM(rdy[0]), .MemErrM(merr[0]), .MemStallM(stall[0])
   );

   dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(2)) u_dut2 (
      .clk(clk), .reset(rst_n[1]), .MemReqM(req[1]), .MemWriteM(we[1]),
      .DataAdrM(adr[1]), .WriteDataM(wd[1]), .ByteEnM(be[1]),
      .ReadDataM(rd[1]), .MemReadyM(rdy[1]), .MemErrM(merr[1]), .MemStallM(stall[1])
   );

   function automatic int ws(int s);
      return (s == 0) ? 0 : 2;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: update the model RAM and queue the response a request should get
   task automatic predict_push(int s, logic w, logic [31:0] a, logic [31:0] d, logic [3:0] b);
      exp_t e;
      int   idx;
      e.err  = (a % 4 != 0) || (a >= 32'(4 * DEPTH));
      idx    = int'((a / 4) % DEPTH);
      e.data = '0;
      if (!e.err) begin
         if (w) begin
            for (int i = 0; i < 4; i++)
               if (b[i]) model[s][idx][8*i +: 8] = d[8*i +: 8];
         end else begin
            e.data = model[s][idx];
         end
      end
      if (s == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   task automatic mon(int s);
      exp_t e;
      if (rdy[s]) begin
         if ((s == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ready%0d: got ready with nothing outstanding at %0t", s, $time);
         end else begin
            e = (s == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("rdata%0d", s), rd[s], e.data);
            chk($sformatf("err%0d", s), 32'(merr[s]), 32'(e.err));
         end
      end else begin
         chk($sformatf("idle_rdata%0d", s), rd[s], 32'h0);
         chk($sformatf("idle_err%0d", s), 32'(merr[s]), 32'h0);
      end
   endtask

   always @(negedge clk) begin
      #1;
      mon(0);
      mon(1);
   end

   // One request held until ready; checks latency and stall cycles
   task automatic do_access(int s, logic w, logic [31:0] a, logic [31:0] d, logic [3:0] b);
      int k;
      int scnt = 0;
      bit got  = 1'b0;
      @(negedge clk);
      we[s] = w; adr[s] = a; wd[s] = d; be[s] = b; req[s] = 1'b1;
      predict_push(s, w, a, d, b);
      #1;
      for (k = 0; k < 40; k++) begin
         if (stall[s]) scnt++;
         if (rdy[s]) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
         #1;
      end
      req[s] = 1'b0;
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL timeout%0d: no ready for adr %h", s, a);
      end else begin
         chk($sformatf("latency%0d", s), 32'(k), 32'(ws(s) + 1));
         chk($sformatf("stall_cycles%0d", s), 32'(scnt), 32'(ws(s) + 1));
      end
   endtask

   function automatic logic [31:0] rand_adr();
      int r;
      r = $urandom_range(0, 9);
      if (r == 0)      return $urandom;
      else if (r == 1) return 32'($urandom_range(0, 4 * DEPTH + 15));
      else             return 32'($urandom_range(0, DEPTH - 1)) << 2;
   endfunction

   initial begin
      int nrdy;
      for (int s = 0; s < 2; s++) begin
         rst_n[s] = 1'b0; req[s] = 1'b0; we[s] = 1'b0;
         adr[s] = '0; wd[s] = '0; be[s] = '0;
      end
      @(negedge clk);
      #2;
      for (int s = 0; s < 2; s++) begin
         chk($sformatf("rst_ready%0d", s), 32'(rdy[s]), 32'h0);
         chk($sformatf("rst_rdata%0d", s), rd[s], 32'h0);
         chk($sformatf("rst_err%0d", s), 32'(merr[s]), 32'h0);
         chk($sformatf("rst_stall%0d", s), 32'(stall[s]), 32'h0);
      end
      @(negedge clk);
      rst_n[0] = 1'b1;
      rst_n[1] = 1'b1;

      // Preload every word so all later reads have known contents
      for (int i = 0; i < int'(DEPTH); i++) begin
         do_access(1, 1'b1, 32'(i * 4), $urandom, 4'hF);
         do_access(0, 1'b1, 32'(i * 4), $urandom, 4'hF);
      end

      // Full-word write then read back
      do_access(1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
      do_access(1, 1'b0, 32'h10, 32'h0, 4'h0);

      // Partial byte-enable write
      do_access(1, 1'b1, 32'h20, 32'h1122_3344, 4'hF);
      do_access(1, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101);
      do_access(1, 1'b0, 32'h20, 32'h0, 4'h0);
      do_access(1, 1'b1, 32'h24, 32'hCAFE_F00D, 4'b0000);
      do_access(1, 1'b0, 32'h24, 32'h0, 4'h0);

      // Error cases, then prove the out-of-range write touched nothing
      do_access(1, 1'b0, 32'h13, 32'h0, 4'h0);
      do_access(1, 1'b0, 32'(4 * DEPTH), 32'h0, 4'h0);
      do_access(1, 1'b1, 32'(4 * DEPTH), 32'h5555_AAAA, 4'hF);
      do_access(1, 1'b1, 32'h8000_0010, 32'h5555_AAAA, 4'hF);
      for (int i = 0; i < int'(DEPTH); i++)
         do_access(1, 1'b0, 32'(i * 4), 32'h0, 4'h0);

      // Zero wait states, request held high: ready on every second cycle
      @(negedge clk);
      we[0] = 1'b0; adr[0] = 32'h0; req[0] = 1'b1;
      predict_push(0, 1'b0, 32'h0, 32'h0, 4'h0);
      #1;
      for (int i = 0; i <= 12; i++) begin
         chk($sformatf("held_ready_c%0d", i), 32'(rdy[0]), 32'((i % 2) == 1));
         if (rdy[0]) begin
            if (i < 11) begin
               adr[0] = 32'($urandom_range(0, DEPTH - 1)) << 2;
               predict_push(0, 1'b0, adr[0], 32'h0, 4'h0);
            end else begin
               req[0] = 1'b0;
            end
         end
         @(negedge clk);
         #1;
      end

      // Reset during the wait cycle of a write discards the write
      do_access(1, 1'b1, 32'h8, 32'h5, 4'hF);
      @(negedge clk);
      we[1] = 1'b1; adr[1] = 32'h8; wd[1] = 32'h1234_5678; be[1] = 4'hF; req[1] = 1'b1;
      @(negedge clk);
      #2;
      rst_n[1] = 1'b0;
      #1;
      chk("rst_mid_ready", 32'(rdy[1]), 32'h0);
      chk("rst_mid_rdata", rd[1], 32'h0);
      chk("rst_mid_err", 32'(merr[1]), 32'h0);
      req[1] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n[1] = 1'b1;
      do_access(1, 1'b0, 32'h8, 32'h0, 4'h0);

      // Requester drops the request one cycle after capture
      @(negedge clk);
      we[1] = 1'b0; adr[1] = 32'h10; req[1] = 1'b1;
      predict_push(1, 1'b0, 32'h10, 32'h0, 4'h0);
      @(negedge clk);
      #2;
      req[1] = 1'b0;
      nrdy = 0;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk("drop_stall", 32'(stall[1]), 32'h0);
         if (rdy[1]) nrdy++;
         @(negedge clk);
         #2;
      end
      chk("drop_ready_count", 32'(nrdy), 32'h1);

      // Random traffic on both instances
      for (int i = 0; i < 150; i++) begin
         do_access(1, 1'($urandom_range(0, 1)), rand_adr(), $urandom, 4'($urandom));
         do_access(0, 1'($urandom_range(0, 1)), rand_adr(), $urandom, 4'($urandom));
      end

      repeat (6) @(negedge clk);
      #2;
      chk("q0_drained", 32'(q0.size()), 32'h0);
      chk("q1_drained", 32'(q1.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish want finish by 2ms");
      $fatal(1);
   end

endmodule
